bcd_counter: RTL and testbench

Multi-digit BCD counter with a prescaled count tick and a time-multiplexed digit scanner. Sits directly upstream of `bcd_deco`: its 4-bit `NUM` output drives `bcd_deco.NUM` one digit at a time. `DIG_SEL` selects the matching display digit.

---
 rtl/bcd_counter.sv | 210 +++++++++++++++++++++
 tb/tb_bcd_counter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter.sv
// ---------------------------------------------------------------------------
// bcd_counter
//   Multi-digit BCD counter with a prescaled count tick and a free-running,
//   time-multiplexed digit scanner that feeds a downstream bcd_deco.
//
//   Optional feature macro: BCD_COUNTER_DOWN_EN
//     defined   : DIR selects up (0) or down (1) counting on each tick.
//     undefined : DIR is ignored and the counter only counts up.
//
//   Ports
//     CLK      in  1          rising-edge clock
//     RST_N    in  1          asynchronous active-low reset
//     EN       in  1          count enable, gates the prescaler
//     CLR      in  1          synchronous clear (highest priority)
//     LOAD     in  1          synchronous load, digits >9 saturate to 9
//     LOAD_VAL in  4*DIGITS   load value, digit 0 in bits [3:0]
//     DIR      in  1          0 = up, 1 = down (macro build only)
//     VALUE    out 4*DIGITS   registered BCD count
//     NUM      out 4          VALUE digit at the current scan index
//     DIG_SEL  out DIGITS     active-low one-hot digit select
//     TC       out 1          one-cycle terminal-count pulse
// ---------------------------------------------------------------------------
module bcd_counter #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 50000,
   parameter int SCAN_DIV = 1000
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  EN,
   input  logic                  CLR,
   input  logic                  LOAD,
   input  logic [4*DIGITS-1:0]   LOAD_VAL,
   input  logic                  DIR,
   output logic [4*DIGITS-1:0]   VALUE,
   output logic [3:0]            NUM,
   output logic [DIGITS-1:0]     DIG_SEL,
   output logic                  TC
);

   localparam int VW = 4 * DIGITS;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
   localparam logic [SW-1:0] SDIV_MAX = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);
   localparam logic [VW-1:0] ALL_NINE = {DIGITS{4'h9}};
   localparam logic [DIGITS-1:0] SEL_ONE = DIGITS'(1'b1);

   // Clamp every loaded digit into the legal BCD range.
   function automatic logic [VW-1:0] sat_load(input logic [VW-1:0] v);
      logic [VW-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
      end
      return r;
   endfunction

   // Ripple-carry BCD increment; 9 rolls to 0 and carries upward.
   function automatic logic [VW-1:0] bcd_inc(input logic [VW-1:0] v);
      logic [VW-1:0] r;
      logic          carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end else begin
            r[4*i +: 4] = v[4*i +: 4];
         end
      end
      return r;
   endfunction

`ifdef BCD_COUNTER_DOWN_EN
   // Ripple-borrow BCD decrement; 0 rolls to 9 and borrows upward.
   function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] v);
      logic [VW-1:0] r;
      logic          borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end else begin
            r[4*i +: 4] = v[4*i +: 4];
         end
      end
      return r;
   endfunction
`endif

   logic [PW-1:0]     pre_r;
   logic [VW-1:0]     value_r;
   logic              tc_r;
   logic [SW-1:0]     sdiv_r;
   logic [IW-1:0]     idx_r;
   logic [DIGITS-1:0] dig_sel_r;

   logic              tick_s;
   logic [VW-1:0]     step_s;
   logic              wrap_s;
   logic [IW-1:0]     idx_next_s;
   logic [3:0]        num_s;

   assign tick_s = EN && (pre_r == PRE_MAX);

   // Next count on a tick, and whether that step wraps the whole counter.
   always_comb begin
      step_s = bcd_inc(value_r);
      wrap_s = (value_r == ALL_NINE);
`ifdef BCD_COUNTER_DOWN_EN
      if (DIR) begin
         step_s = bcd_dec(value_r);
         wrap_s = (value_r == {VW{1'b0}});
      end else begin
         step_s = bcd_inc(value_r);
         wrap_s = (value_r == ALL_NINE);
      end
`endif
   end

`ifndef BCD_COUNTER_DOWN_EN
   logic unused_dir_s;
   assign unused_dir_s = DIR;
`endif

   // Prescaler: restarts on clear/load, freezes while EN is low.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pre_r <= {PW{1'b0}};
      end else if (CLR || LOAD) begin
         pre_r <= {PW{1'b0}};
      end else if (EN) begin
         pre_r <= (pre_r == PRE_MAX) ? {PW{1'b0}} : pre_r + PW'(1'b1);
      end else begin
         pre_r <= pre_r;
      end
   end

   // Count register and terminal-count pulse; clear/load discard a tick.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         value_r <= {VW{1'b0}};
         tc_r    <= 1'b0;
      end else if (CLR) begin
         value_r <= {VW{1'b0}};
         tc_r    <= 1'b0;
      end else if (LOAD) begin
         value_r <= sat_load(LOAD_VAL);
         tc_r    <= 1'b0;
      end else if (tick_s) begin
         value_r <= step_s;
         tc_r    <= wrap_s;
      end else begin
         value_r <= value_r;
         tc_r    <= 1'b0;
      end
   end

   // Scan index after the current divider cycle.
   always_comb begin
      if (sdiv_r == SDIV_MAX) begin
         idx_next_s = (idx_r == IDX_MAX) ? {IW{1'b0}} : idx_r + IW'(1'b1);
      end else begin
         idx_next_s = idx_r;
      end
   end

   // Free-running scanner; the select is registered alongside the index
   // so NUM (muxed from idx_r) and DIG_SEL always move on the same edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sdiv_r    <= {SW{1'b0}};
         idx_r     <= {IW{1'b0}};
         dig_sel_r <= ~SEL_ONE;
      end else begin
         sdiv_r    <= (sdiv_r == SDIV_MAX) ? {SW{1'b0}} : sdiv_r + SW'(1'b1);
         idx_r     <= idx_next_s;
         dig_sel_r <= ~(SEL_ONE << idx_next_s);
      end
   end

   // Digit mux for the decoder.
   always_comb begin
      num_s = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         num_s = (idx_r == IW'(i)) ? value_r[4*i +: 4] : num_s;
      end
   end

   assign VALUE   = value_r;
   assign TC      = tc_r;
   assign DIG_SEL = dig_sel_r;
   assign NUM     = num_s;

endmodule

// File: tb/tb_bcd_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_counter
//   Self-checking bench for bcd_counter (DIGITS=4, PRESCALE=2, SCAN_DIV=1).
//   A decimal-integer reference model tracks the count, prescaler and scan
//   index; directed scenarios and a randomized run compare against it.
// ---------------------------------------------------------------------------
module tb_bcd_counter;

   localparam int DIGITS   = 4;
   localparam int PRESCALE = 2;
   localparam int SCAN_DIV = 1;
`ifdef BCD_COUNTER_DOWN_EN
   localparam bit DOWN_EN = 1'b1;
`else
   localparam bit DOWN_EN = 1'b0;
`endif

   logic        CLK;
   logic        RST_N;
   logic        EN;
   logic        CLR;
   logic        LOAD;
   logic [15:0] LOAD_VAL;
   logic        DIR;
   logic [15:0] VALUE;
   logic [3:0]  NUM;
   logic [3:0]  DIG_SEL;
   logic        TC;

   int total = 0;
   int bad   = 0;

   bcd_counter #(
      .DIGITS   (DIGITS),
      .PRESCALE (PRESCALE),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .EN       (EN),
      .CLR      (CLR),
      .LOAD     (LOAD),
      .LOAD_VAL (LOAD_VAL),
      .DIR      (DIR),
      .VALUE    (VALUE),
      .NUM      (NUM),
      .DIG_SEL  (DIG_SEL),
      .TC       (TC)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- reference model (decimal integer) ----------------
   int m_val  = 0;
   int m_pre  = 0;
   int m_sdiv = 0;
   int m_idx  = 0;
   bit m_tc   = 1'b0;
   bit m_tick;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int t;
      t = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int sat_dec(input logic [15:0] v);
      int r, m, d;
      r = 0;
      m = 1;
      for (int i = 0; i < 4; i++) begin
         d = int'(v[4*i +: 4]);
         if (d > 9) d = 9;
         r = r + d * m;
         m = m * 10;
      end
      return r;
   endfunction

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_val = 0; m_pre = 0; m_sdiv = 0; m_idx = 0; m_tc = 1'b0;
      end else begin
         m_tick = EN && (m_pre == PRESCALE - 1);
         if (CLR) begin
            m_val = 0; m_pre = 0; m_tc = 1'b0;
         end else if (LOAD) begin
            m_val = sat_dec(LOAD_VAL); m_pre = 0; m_tc = 1'b0;
         end else begin
            if (EN) m_pre = (m_pre + 1) % PRESCALE;
            if (m_tick) begin
               if (DOWN_EN && DIR) begin
                  m_tc  = (m_val == 0);
                  m_val = (m_val + 9999) % 10000;
               end else begin
                  m_tc  = (m_val == 9999);
                  m_val = (m_val + 1) % 10000;
               end
            end else begin
               m_tc = 1'b0;
            end
         end
         if (m_sdiv == SCAN_DIV - 1) begin
            m_sdiv = 0;
            m_idx  = (m_idx + 1) % DIGITS;
         end else begin
            m_sdiv = m_sdiv + 1;
         end
      end
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      RST_N = 1'b1; EN = 1'b0; CLR = 1'b0; LOAD = 1'b0; DIR = 1'b0; LOAD_VAL = 16'h0000;
      #2 RST_N = 1'b0;
      @(negedge CLK);
      total++; if (VALUE !== 16'h0000) begin bad++; $display("FAIL reset_value got=%h exp=0000", VALUE); end
      total++; if (NUM !== 4'd0) begin bad++; $display("FAIL reset_num got=%h exp=0", NUM); end
      total++; if (DIG_SEL !== 4'b1110) begin bad++; $display("FAIL reset_dig_sel got=%b exp=1110", DIG_SEL); end
      total++; if (TC !== 1'b0) begin bad++; $display("FAIL reset_tc got=%b exp=0", TC); end
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic test_count_up();
      logic [15:0] ev;
      EN = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         ev = to_bcd(m_val);
         total++; if (VALUE !== ev) begin bad++; $display("FAIL count_up_value cyc=%0d got=%h exp=%h", i, VALUE, ev); end
         total++; if (TC !== 1'b0) begin bad++; $display("FAIL count_up_tc cyc=%0d got=%b exp=0", i, TC); end
      end
      total++; if (VALUE !== 16'h0010) begin bad++; $display("FAIL count_up_final got=%h exp=0010", VALUE); end
      EN = 1'b0;
   endtask

   task automatic test_carry();
      LOAD = 1'b1; LOAD_VAL = 16'h0999;
      @(negedge CLK);
      LOAD = 1'b0;
      total++; if (VALUE !== 16'h0999) begin bad++; $display("FAIL carry_load got=%h exp=0999", VALUE); end
      EN = 1'b1;
      repeat (2) @(negedge CLK);
      total++; if (VALUE !== 16'h1000) begin bad++; $display("FAIL carry_tick1 got=%h exp=1000", VALUE); end
      repeat (2) @(negedge CLK);
      total++; if (VALUE !== 16'h1001) begin bad++; $display("FAIL carry_tick2 got=%h exp=1001", VALUE); end
      EN = 1'b0;
   endtask

   task automatic test_wrap();
      LOAD = 1'b1; LOAD_VAL = 16'h9999;
      @(negedge CLK);
      LOAD = 1'b0; EN = 1'b1;
      @(negedge CLK);
      total++; if (VALUE !== 16'h9999 || TC !== 1'b0) begin bad++; $display("FAIL wrap_pre got=%h/%b exp=9999/0", VALUE, TC); end
      @(negedge CLK);
      total++; if (VALUE !== 16'h0000) begin bad++; $display("FAIL wrap_value got=%h exp=0000", VALUE); end
      total++; if (TC !== 1'b1) begin bad++; $display("FAIL wrap_tc got=%b exp=1", TC); end
      @(negedge CLK);
      total++; if (TC !== 1'b0) begin bad++; $display("FAIL wrap_tc_pulse got=%b exp=0", TC); end
      EN = 1'b0;
   endtask

   task automatic test_load_clr();
      LOAD = 1'b1; LOAD_VAL = 16'h12FA;
      @(negedge CLK);
      LOAD = 1'b0;
      total++; if (VALUE !== 16'h1299) begin bad++; $display("FAIL load_sat got=%h exp=1299", VALUE); end
      EN = 1'b1;
      @(negedge CLK);
      CLR = 1'b1; LOAD = 1'b1; LOAD_VAL = 16'h5555;
      @(negedge CLK);
      total++; if (VALUE !== 16'h0000 || TC !== 1'b0) begin bad++; $display("FAIL clr_load got=%h/%b exp=0000/0", VALUE, TC); end
      CLR = 1'b0; LOAD = 1'b0;
      @(negedge CLK);
      total++; if (VALUE !== 16'h0000 || TC !== 1'b0) begin bad++; $display("FAIL clr_tick_lost got=%h/%b exp=0000/0", VALUE, TC); end
      EN = 1'b0;
   endtask

   task automatic test_scan();
      logic [3:0] exp_num [4];
      logic [3:0] exp_sel [4];
      exp_num = '{4'd1, 4'd2, 4'd3, 4'd4};
      exp_sel = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      LOAD = 1'b1; LOAD_VAL = 16'h4321;
      @(negedge CLK);
      LOAD = 1'b0;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (NUM !== exp_num[m_idx] || DIG_SEL !== exp_sel[m_idx]) begin
            bad++; $display("FAIL scan cyc=%0d got=%h/%b exp=%h/%b", i, NUM, DIG_SEL, exp_num[m_idx], exp_sel[m_idx]);
         end
         @(negedge CLK);
      end
      #2 RST_N = 1'b0;
      #1;
      total++; if (NUM !== 4'd0 || DIG_SEL !== 4'b1110) begin bad++; $display("FAIL scan_async_reset got=%h/%b exp=0/1110", NUM, DIG_SEL); end
      total++; if (VALUE !== 16'h0000 || TC !== 1'b0) begin bad++; $display("FAIL async_reset_value got=%h/%b exp=0000/0", VALUE, TC); end
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      total++; if (DIG_SEL !== 4'b1101 || NUM !== 4'd0) begin bad++; $display("FAIL scan_after_reset got=%h/%b exp=0/1101", NUM, DIG_SEL); end
   endtask

   task automatic test_dir();
      logic [15:0] ev;
      ev = DOWN_EN ? 16'h9999 : 16'h0001;
      DIR = 1'b1; LOAD = 1'b1; LOAD_VAL = 16'h0000;
      @(negedge CLK);
      LOAD = 1'b0; EN = 1'b1;
      repeat (2) @(negedge CLK);
      total++; if (VALUE !== ev) begin bad++; $display("FAIL dir_value got=%h exp=%h", VALUE, ev); end
      total++; if (TC !== DOWN_EN) begin bad++; $display("FAIL dir_tc got=%b exp=%b", TC, DOWN_EN); end
      EN = 1'b0; DIR = 1'b0;
   endtask

   task automatic test_random();
      logic [15:0] ev;
      logic [3:0]  en;
      logic [3:0]  es;
      for (int i = 0; i < 600; i++) begin
         EN  = ($urandom_range(0, 9) < 7);
         CLR = ($urandom_range(0, 39) == 0);
         LOAD = ($urandom_range(0, 19) == 0);
         DIR = $urandom_range(0, 1) == 1;
         case ($urandom_range(0, 3))
            0: LOAD_VAL = 16'h9998;
            1: LOAD_VAL = 16'h0001;
            default: LOAD_VAL = 16'($urandom);
         endcase
         @(negedge CLK);
         ev = to_bcd(m_val);
         en = ev[4*m_idx +: 4];
         es = ~(4'b0001 << m_idx);
         total++; if (VALUE !== ev) begin bad++; $display("FAIL rnd_value cyc=%0d got=%h exp=%h", i, VALUE, ev); end
         total++; if (TC !== m_tc) begin bad++; $display("FAIL rnd_tc cyc=%0d got=%b exp=%b", i, TC, m_tc); end
         total++; if (NUM !== en) begin bad++; $display("FAIL rnd_num cyc=%0d got=%h exp=%h", i, NUM, en); end
         total++; if (DIG_SEL !== es) begin bad++; $display("FAIL rnd_dig_sel cyc=%0d got=%b exp=%b", i, DIG_SEL, es); end
      end
      EN = 1'b0; CLR = 1'b0; LOAD = 1'b0; DIR = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_carry();
      test_wrap();
      test_load_clr();
      test_scan();
      test_dir();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
